imem_fetch_port: RTL

Parametrised instruction memory for the superscalar front end. Each accepted fetch PC returns `FETCH_W` consecutive 32-bit instruction words through a valid/ready request and response handshake. A 2-entry response buffer absorbs decode back-pressure, and a flush input cancels all outstanding responses. A runtime programming port loads test programs. The block sits between the fetch PC generator and the fetch/decode queue.

---
 rtl/imem_fetch_port.sv | 124 ++++++++++++
 1 files changed

// File: rtl/imem_fetch_port.sv
// Instruction memory with a valid/ready fetch port returning FETCH_W words per PC,
// a 2-entry response buffer and a programming port. Define IMEM_BOUNDS_CHECK_EN for range checks.
module imem_fetch_port #(
   parameter int XLEN    = 32,
   parameter int DEPTH   = 2048,
   parameter int FETCH_W = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [XLEN-1:0]         req_pc,
   input  logic                    flush,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [XLEN-1:0]         resp_pc,
   output logic [FETCH_W*XLEN-1:0] resp_data,
   output logic [FETCH_W-1:0]      resp_lane_valid,
   output logic                    resp_fault,
   input  logic                    prog_en,
   input  logic [XLEN-1:0]         prog_addr,
   input  logic [XLEN-1:0]         prog_data
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0]         pc;
      logic [FETCH_W*XLEN-1:0] data;
      logic [FETCH_W-1:0]      lane_valid;
      logic                    fault;
   } resp_t;

   logic [XLEN-1:0] mem_q [DEPTH] = '{default: '1};

   resp_t      rd_resp;
   resp_t      fifo_q [2];
   logic [1:0] count_q, count_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic       wr_ptr_q, wr_ptr_d;
   logic       push, pop;
   logic       prog_ok;
   logic       unused_addr_bits;

   assign unused_addr_bits = ^{req_pc[1:0], prog_addr};

   // NOTE: every variable driven here gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      rd_resp    = '0;
      rd_resp.pc = {req_pc[XLEN-1:2], 2'b00};
      for (int i = 0; i < FETCH_W; i++) begin
`ifdef IMEM_BOUNDS_CHECK_EN
         logic [XLEN:0] idx;
         idx = {3'b000, req_pc[XLEN-1:2]} + (XLEN+1)'(i);
         if (idx < (XLEN+1)'(DEPTH)) begin
            rd_resp.data[i*XLEN +: XLEN] = mem_q[idx[AW-1:0]];
            rd_resp.lane_valid[i]        = 1'b1;
         end else begin
            rd_resp.data[i*XLEN +: XLEN] = '1;
            rd_resp.fault                = 1'b1;
         end
`else
         logic [AW-1:0] widx;
         widx = req_pc[AW+1:2] + AW'(i);
         rd_resp.data[i*XLEN +: XLEN] = mem_q[widx];
         rd_resp.lane_valid[i]        = 1'b1;
`endif
      end
   end

`ifdef IMEM_BOUNDS_CHECK_EN
   assign prog_ok = ({2'b00, prog_addr[XLEN-1:2]} < XLEN'(DEPTH));
`else
   assign prog_ok = 1'b1;
`endif

   // NOTE: the memory array has no reset; its contents must survive reset and a reset branch would block RAM inference.
   always_ff @(posedge clk) begin
      if (prog_en && prog_ok) begin
         mem_q[prog_addr[AW+1:2]] <= prog_data;
      end
   end

   // req_ready deliberately ignores resp_ready so the PC generator never sees a combinational loop.
   assign req_ready  = (count_q != 2'd2) & ~flush & ~prog_en & ~reset;
   assign resp_valid = (count_q != 2'd0);
   assign push       = req_valid & req_ready;
   assign pop        = resp_valid & resp_ready & ~flush;

   always_comb begin
      count_d  = count_q + 2'(push) - 2'(pop);
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
      if (flush) begin
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         count_q   <= 2'd0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= rd_resp;
         end
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   assign resp_pc         = fifo_q[rd_ptr_q].pc;
   assign resp_data       = fifo_q[rd_ptr_q].data;
   assign resp_lane_valid = fifo_q[rd_ptr_q].lane_valid;
   assign resp_fault      = fifo_q[rd_ptr_q].fault;

endmodule
